// File: rtl/fetch_pkg.sv
// Shared defaults, halt-word encoding and fetch FSM state type for the fetch sequencer.
package fetch_pkg;
   localparam int ADDR_W_DEF   = 6;
   localparam int INSTR_W_DEF  = 32;
   localparam int RESET_PC_DEF = 0;
   localparam logic [31:0] HALT_WORD = 32'h0;

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HALT} state_t;
endpackage

// File: rtl/fetch_out_reg.sv
// Instruction holding register toward decode: loads a fetched word, flushes on redirect/halt.
// room reports that the register is empty or being drained by decode this cycle.
module fetch_out_reg #(
   parameter int ADDR_W  = 6,
   parameter int INSTR_W = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load,
   input  logic               flush,
   input  logic               ready,
   input  logic [INSTR_W-1:0] d_instr,
   input  logic [ADDR_W-1:0]  d_pc,
   output logic               room,
   output logic [INSTR_W-1:0] instr_out,
   output logic [ADDR_W-1:0]  instr_pc,
   output logic               instr_valid
);
   assign room = !instr_valid || ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         instr_out   <= '0;
         instr_pc    <= '0;
         instr_valid <= 1'b0;
      end else if (flush) begin
         instr_valid <= 1'b0;
      end else if (load) begin
         instr_out   <= d_instr;
         instr_pc    <= d_pc;
         instr_valid <= 1'b1;
      end
   end
endmodule

// File: rtl/fetch_sequencer.sv
// PC sequencer and fetch stage: one word/cycle into a valid/ready register, redirect beats load.
// Define FETCH_HALT_EN to stop fetching (HALT state) on an all-zero instruction word.
module fetch_sequencer
   import fetch_pkg::*;
#(
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int INSTR_W  = INSTR_W_DEF,
   parameter int RESET_PC = RESET_PC_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   output logic [ADDR_W-1:0]  pc_addr,
   input  logic [INSTR_W-1:0] instr_in,
   output logic [INSTR_W-1:0] instr_out,
   output logic [ADDR_W-1:0]  instr_pc,
   output logic               instr_valid,
   input  logic               instr_ready,
   input  logic               redirect_valid,
   input  logic [ADDR_W-1:0]  redirect_addr,
   output logic               halted
);
   state_t            state, state_nxt;
   logic [ADDR_W-1:0] pc_nxt;
   logic              load, flush, room;

   fetch_out_reg #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) u_out (
      .clk         (clk),
      .rst         (rst),
      .load        (load),
      .flush       (flush),
      .ready       (instr_ready),
      .d_instr     (instr_in),
      .d_pc        (pc_addr),
      .room        (room),
      .instr_out   (instr_out),
      .instr_pc    (instr_pc),
      .instr_valid (instr_valid)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= S_IDLE;
         pc_addr <= ADDR_W'(RESET_PC);
         halted  <= 1'b0;
      end else begin
         state   <= state_nxt;
         pc_addr <= pc_nxt;
         halted  <= (state_nxt == S_HALT);
      end
   end

   always_comb begin
      state_nxt = state;
      pc_nxt    = pc_addr;
      load      = 1'b0;
      flush     = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               state_nxt = S_FETCH;
               pc_nxt    = ADDR_W'(RESET_PC);
            end
         end
         S_FETCH: begin
            // A taken redirect drops whatever is held; a word accepted this cycle is still consumed.
            if (redirect_valid) begin
               pc_nxt = redirect_addr;
               flush  = 1'b1;
            end else if (room) begin
`ifdef FETCH_HALT_EN
               if (instr_in == INSTR_W'(HALT_WORD)) begin
                  flush     = 1'b1;
                  state_nxt = S_HALT;
               end else begin
                  load   = 1'b1;
                  pc_nxt = pc_addr + 1'b1;
               end
`else
               load   = 1'b1;
               pc_nxt = pc_addr + 1'b1;
`endif
            end
         end
         S_HALT: begin
            if (redirect_valid) begin
               state_nxt = S_FETCH;
               pc_nxt    = redirect_addr;
            end else if (start) begin
               state_nxt = S_FETCH;
               pc_nxt    = ADDR_W'(RESET_PC);
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end
endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios plus random ready/redirect/start traffic
// scored against an in-order delivery model of the program stream.
module tb_fetch_sequencer;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic        instr_ready = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [5:0]  redirect_addr = '0;
   logic [5:0]  pc_addr, instr_pc;
   logic [31:0] instr_in, instr_out;
   logic        instr_valid, halted;
   logic [31:0] mem [64];
   int          total = 0;
   int          bad = 0;

   fetch_sequencer dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .pc_addr        (pc_addr),
      .instr_in       (instr_in),
      .instr_out      (instr_out),
      .instr_pc       (instr_pc),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .redirect_valid (redirect_valid),
      .redirect_addr  (redirect_addr),
      .halted         (halted)
   );

   always #5 clk = ~clk;
   assign instr_in = mem[pc_addr];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load_spec_mem();
      for (int i = 0; i < 64; i++) mem[i] = 32'h0;
      mem[0] = 32'h0020_0003;
      mem[1] = 32'h0020_0002;
      mem[2] = 32'h1064_0022;
   endtask

   task automatic reset_start();
      rst = 1'b1; start = 1'b0; instr_ready = 1'b0; redirect_valid = 1'b0; redirect_addr = '0;
      step();
      rst = 1'b0;
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic test_reset();
      #2 rst = 1'b1;
      #2;
      total++; if (pc_addr !== 6'd0) begin bad++; $display("FAIL reset_pc_addr got=%0d exp=0", pc_addr); end
      total++; if (instr_out !== 32'h0) begin bad++; $display("FAIL reset_instr_out got=%h exp=0", instr_out); end
      total++; if (instr_pc !== 6'd0) begin bad++; $display("FAIL reset_instr_pc got=%0d exp=0", instr_pc); end
      total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", instr_valid); end
      total++; if (halted !== 1'b0) begin bad++; $display("FAIL reset_halted got=%b exp=0", halted); end
      step();
      rst = 1'b0;
      redirect_valid = 1'b1; redirect_addr = 6'd5; instr_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         total++;
         if (pc_addr !== 6'd0 || instr_valid !== 1'b0) begin
            bad++; $display("FAIL idle_ignore pc=%0d valid=%b exp pc=0 valid=0", pc_addr, instr_valid);
         end
      end
      redirect_valid = 1'b0;
   endtask

   task automatic test_stream();
      logic [31:0] exp_w [3];
      exp_w[0] = 32'h0020_0003; exp_w[1] = 32'h0020_0002; exp_w[2] = 32'h1064_0022;
      reset_start();
      total++;
      if (pc_addr !== 6'd0 || instr_valid !== 1'b0) begin
         bad++; $display("FAIL start_first_addr pc=%0d valid=%b exp pc=0 valid=0", pc_addr, instr_valid);
      end
      instr_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         total++;
         if (instr_valid !== 1'b1 || instr_out !== exp_w[k] || instr_pc !== 6'(k) || pc_addr !== 6'(k + 1)) begin
            bad++;
            $display("FAIL stream_%0d got v=%b out=%h ipc=%0d pc=%0d exp v=1 out=%h ipc=%0d pc=%0d",
                     k, instr_valid, instr_out, instr_pc, pc_addr, exp_w[k], k, k + 1);
         end
      end
   endtask

   task automatic test_stall();
      reset_start();
      instr_ready = 1'b1;
      step();
      instr_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         total++;
         if (instr_valid !== 1'b1 || instr_out !== 32'h0020_0003 || instr_pc !== 6'd0 || pc_addr !== 6'd1) begin
            bad++;
            $display("FAIL stall_hold_%0d got v=%b out=%h ipc=%0d pc=%0d exp v=1 out=00200003 ipc=0 pc=1",
                     k, instr_valid, instr_out, instr_pc, pc_addr);
         end
      end
      instr_ready = 1'b1;
      step();
      total++;
      if (instr_valid !== 1'b1 || instr_out !== 32'h0020_0002 || instr_pc !== 6'd1) begin
         bad++; $display("FAIL stall_release got out=%h ipc=%0d exp out=00200002 ipc=1", instr_out, instr_pc);
      end
      step();
      total++;
      if (instr_out !== 32'h1064_0022 || instr_pc !== 6'd2) begin
         bad++; $display("FAIL stall_next got out=%h ipc=%0d exp out=10640022 ipc=2", instr_out, instr_pc);
      end
   endtask

   task automatic test_redirect();
      reset_start();
      instr_ready = 1'b1;
      step();
      redirect_valid = 1'b1; redirect_addr = 6'd2;
      step();
      redirect_valid = 1'b0;
      total++;
      if (instr_valid !== 1'b0 || pc_addr !== 6'd2) begin
         bad++; $display("FAIL redirect_flush got v=%b pc=%0d exp v=0 pc=2", instr_valid, pc_addr);
      end
      step();
      total++;
      if (instr_valid !== 1'b1 || instr_out !== 32'h1064_0022 || instr_pc !== 6'd2) begin
         bad++; $display("FAIL redirect_target got v=%b out=%h ipc=%0d exp v=1 out=10640022 ipc=2",
                         instr_valid, instr_out, instr_pc);
      end
   endtask

   task automatic test_halt();
      reset_start();
      instr_ready = 1'b1;
      for (int k = 0; k < 3; k++) step();
      step();
`ifdef FETCH_HALT_EN
      total++;
      if (halted !== 1'b1 || instr_valid !== 1'b0 || pc_addr !== 6'd3) begin
         bad++; $display("FAIL halt_enter got h=%b v=%b pc=%0d exp h=1 v=0 pc=3", halted, instr_valid, pc_addr);
      end
      step();
      total++;
      if (halted !== 1'b1 || instr_valid !== 1'b0) begin
         bad++; $display("FAIL halt_stay got h=%b v=%b exp h=1 v=0", halted, instr_valid);
      end
      start = 1'b1;
      step();
      start = 1'b0;
      total++;
      if (halted !== 1'b0 || pc_addr !== 6'd0) begin
         bad++; $display("FAIL halt_restart got h=%b pc=%0d exp h=0 pc=0", halted, pc_addr);
      end
      step();
      total++;
      if (instr_valid !== 1'b1 || instr_out !== 32'h0020_0003 || instr_pc !== 6'd0) begin
         bad++; $display("FAIL halt_resume got v=%b out=%h ipc=%0d exp v=1 out=00200003 ipc=0",
                         instr_valid, instr_out, instr_pc);
      end
`else
      total++;
      if (instr_valid !== 1'b1 || instr_out !== 32'h0 || instr_pc !== 6'd3 || halted !== 1'b0) begin
         bad++; $display("FAIL zero_word got v=%b out=%h ipc=%0d h=%b exp v=1 out=0 ipc=3 h=0",
                         instr_valid, instr_out, instr_pc, halted);
      end
`endif
   endtask

   task automatic test_wrap_reset();
      mem[63] = 32'hDEAD_BEEF;
      reset_start();
      instr_ready = 1'b1;
      step();
      redirect_valid = 1'b1; redirect_addr = 6'd63;
      step();
      redirect_valid = 1'b0;
      total++;
      if (instr_valid !== 1'b0 || pc_addr !== 6'd63) begin
         bad++; $display("FAIL wrap_redirect got v=%b pc=%0d exp v=0 pc=63", instr_valid, pc_addr);
      end
      step();
      total++;
      if (instr_pc !== 6'd63 || instr_out !== 32'hDEAD_BEEF || pc_addr !== 6'd0) begin
         bad++; $display("FAIL wrap_last got ipc=%0d out=%h pc=%0d exp ipc=63 out=deadbeef pc=0",
                         instr_pc, instr_out, pc_addr);
      end
      step();
      total++;
      if (instr_pc !== 6'd0 || instr_out !== 32'h0020_0003) begin
         bad++; $display("FAIL wrap_first got ipc=%0d out=%h exp ipc=0 out=00200003", instr_pc, instr_out);
      end
      step();
      #3 rst = 1'b1;
      #1;
      total++;
      if (instr_valid !== 1'b0 || pc_addr !== 6'd0 || instr_pc !== 6'd0 || instr_out !== 32'h0 || halted !== 1'b0) begin
         bad++; $display("FAIL async_reset got v=%b pc=%0d ipc=%0d out=%h h=%b exp all 0",
                         instr_valid, pc_addr, instr_pc, instr_out, halted);
      end
      step();
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         total++;
         if (instr_valid !== 1'b0 || pc_addr !== 6'd0) begin
            bad++; $display("FAIL post_reset_idle got v=%b pc=%0d exp v=0 pc=0", instr_valid, pc_addr);
         end
      end
      instr_ready = 1'b0;
      mem[63] = 32'h0;
   endtask

   task automatic test_random();
      logic [5:0] exp_next;
      int         hs;
      logic       rdy, redir, st;
      logic [5:0] raddr;
      for (int i = 0; i < 64; i++) mem[i] = $urandom | 32'h1;
      reset_start();
      exp_next = 6'd0;
      hs = 0;
      for (int c = 0; c < 600; c++) begin
         rdy   = ($urandom_range(0, 3) != 0);
         redir = ($urandom_range(0, 15) == 0);
         raddr = 6'($urandom_range(0, 63));
         st    = ($urandom_range(0, 31) == 0);
         total++;
         if (halted !== 1'b0) begin bad++; $display("FAIL rand_halted cyc=%0d got=%b exp=0", c, halted); end
         if (instr_valid === 1'b1) begin
            total++;
            if (instr_pc !== exp_next || instr_out !== mem[exp_next]) begin
               bad++; $display("FAIL rand_word cyc=%0d got ipc=%0d out=%h exp ipc=%0d out=%h",
                               c, instr_pc, instr_out, exp_next, mem[exp_next]);
            end
         end
         if (instr_valid === 1'b1 && rdy) begin
            exp_next = exp_next + 6'd1;
            hs++;
         end
         if (redir) exp_next = raddr;
         instr_ready = rdy; redirect_valid = redir; redirect_addr = raddr; start = st;
         step();
      end
      instr_ready = 1'b0; redirect_valid = 1'b0; start = 1'b0;
      total++;
      if (hs < 150) begin bad++; $display("FAIL rand_throughput got=%0d handshakes exp>=150", hs); end
   endtask

   initial begin
      load_spec_mem();
      test_reset();
      test_stream();
      test_stall();
      test_redirect();
      test_halt();
      test_wrap_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
